// File: rtl/wb_queue.sv
// wb_queue: ordered writeback buffer that merges ALU and load results onto one register-file write port.
// Latency: an entry is presented one cycle after acceptance. Backpressure: ready is sampled from the registered count, ALU first. Forwarding is built under WB_FWD_EN.
module wb_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AWIDTH-1:0]          alu_addr,
  input  logic [DWIDTH-1:0]          alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AWIDTH-1:0]          mem_addr,
  input  logic [DWIDTH-1:0]          mem_data,
  output logic                       we,
  output logic [AWIDTH-1:0]          wa,
  output logic [DWIDTH-1:0]          wd,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [AWIDTH-1:0]          ra1,
  input  logic [AWIDTH-1:0]          ra2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [DWIDTH-1:0]          fwd1_data,
  output logic [DWIDTH-1:0]          fwd2_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } ent_t;

  ent_t          ent_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic [CW-1:0] free;
  logic          alu_enq;
  logic          mem_enq;
  logic          alu_push;
  logic          mem_push;
  logic          pop;
  logic [PW-1:0] mem_slot;

  // Free space deliberately ignores the pop happening this cycle.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    alu_enq   = alu_valid && (alu_addr != '0);
    mem_enq   = mem_valid && (mem_addr != '0);
    alu_ready = (free >= CW'(1));
    mem_ready = (free >= CW'(2)) || ((free == CW'(1)) && !alu_enq);
    alu_push  = alu_enq && alu_ready;
    mem_push  = mem_enq && mem_ready;
    pop       = (count_q != '0);
    mem_slot  = tail_q + PW'(alu_push);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(pop);
      tail_q  <= tail_q + PW'(alu_push) + PW'(mem_push);
      count_q <= count_q + CW'(alu_push) + CW'(mem_push) - CW'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (alu_push) ent_q[tail_q] <= '{addr: alu_addr, data: alu_data};
      if (mem_push) ent_q[mem_slot] <= '{addr: mem_addr, data: mem_data};
    end
  end

  always_comb begin
    we    = pop;
    wa    = pop ? ent_q[head_q].addr : '0;
    wd    = pop ? ent_q[head_q].data : '0;
    count = count_q;
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match wins.
  function automatic logic [DWIDTH:0] lookup(input logic [AWIDTH-1:0] ra);
    logic [DWIDTH:0] res;
    logic [PW-1:0]   slot;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (ra != '0) && (ent_q[slot].addr == ra)) begin
        res = {1'b1, ent_q[slot].data};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(ra1);
    {fwd2_hit, fwd2_data} = lookup(ra2);
  end
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};

  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed and random stimulus for wb_queue against a queue-based reference model.
module tb_wb_queue;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [CW-1:0] count;
  logic [AW-1:0] ra1, ra2;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;

  wb_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .we(we), .wa(wa), .wd(wd), .count(count),
    .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   chk_en;
  bit   alu_hs, mem_hs;
  int   max_cnt;
  int   n_enq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: youngest queued entry with a matching nonzero address.
  function automatic void model_fwd(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
`ifdef WB_FWD_EN
    if (ra != '0) begin
      foreach (q[i]) begin
        if (q[i].a == ra) begin
          h = 1'b1;
          d = q[i].d;
        end
      end
    end
`endif
  endfunction

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    int            free;
    bit            ae, er_a, er_m;
    logic          h1, h2;
    logic [DW-1:0] d1, d2;
    #1;
    free = DEPTH - q.size();
    ae   = alu_valid && (alu_addr != 0);
    er_a = (free >= 1);
    er_m = (free >= 2) || ((free == 1) && !ae);
    if (chk_en) begin
      model_fwd(ra1, h1, d1);
      model_fwd(ra2, h2, d2);
      check("alu_ready", {63'd0, alu_ready}, {63'd0, er_a});
      check("mem_ready", {63'd0, mem_ready}, {63'd0, er_m});
      check("count", 64'(count), 64'(q.size()));
      check("we", {63'd0, we}, {63'd0, (q.size() != 0)});
      check("wa", 64'(wa), (q.size() != 0) ? 64'(q[0].a) : 64'd0);
      check("wd", 64'(wd), (q.size() != 0) ? 64'(q[0].d) : 64'd0);
      check("fwd1", {31'd0, fwd1_hit, fwd1_data}, {31'd0, h1, d1});
      check("fwd2", {31'd0, fwd2_hit, fwd2_data}, {31'd0, h2, d2});
    end
    alu_hs = alu_valid && er_a;
    mem_hs = mem_valid && er_m;
    if (!rst_n) begin
      q.delete();
      alu_hs = 1'b0;
      mem_hs = 1'b0;
    end else begin
      if (q.size() != 0) void'(q.pop_front());
      if (alu_hs && alu_addr != 0) begin q.push_back('{a: alu_addr, d: alu_data}); n_enq++; end
      if (mem_hs && mem_addr != 0) begin q.push_back('{a: mem_addr, d: mem_data}); n_enq++; end
    end
    if (q.size() > max_cnt) max_cnt = q.size();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
  endtask

  initial begin
    logic exp_h;
    idle_inputs();
    ra1 = '0; ra2 = '0;
    rst_n = 1'b0; chk_en = 1'b0; max_cnt = 0; n_enq = 0;
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state and single write
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
    check("rst_mem_ready", {63'd0, mem_ready}, 64'd1);
    alu_valid = 1'b1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    cyc();
    idle_inputs();
    #1;
    check("t1_we", {63'd0, we}, 64'd1);
    check("t1_wa", 64'(wa), 64'd5);
    check("t1_wd", 64'(wd), 64'hDEADBEEF);
    check("t1_count", 64'(count), 64'd1);
    cyc();
    #1;
    check("t1_we_after", {63'd0, we}, 64'd0);
    check("t1_count_after", 64'(count), 64'd0);
    cyc();

    // x0 drop alongside a real load result
    max_cnt = 0;
    alu_valid = 1'b1; alu_addr = 0; alu_data = 32'h1234;
    mem_valid = 1'b1; mem_addr = 3; mem_data = 7;
    #1;
    check("x0_alu_ready", {63'd0, alu_ready}, 64'd1);
    check("x0_mem_ready", {63'd0, mem_ready}, 64'd1);
    cyc();
    idle_inputs();
    #1;
    check("x0_wa", 64'(wa), 64'd3);
    check("x0_wd", 64'(wd), 64'd7);
    cyc();
    cyc();
    check("x0_peak", 64'(max_cnt), 64'd1);

    // Dual accept ordering and youngest-match forwarding
    alu_valid = 1'b1; alu_addr = 1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 1; mem_data = 32'h22;
    ra1 = 1;
    cyc();
    idle_inputs();
    #1;
`ifdef WB_FWD_EN
    exp_h = 1'b1;
`else
    exp_h = 1'b0;
`endif
    check("dual_wd0", 64'(wd), 64'h11);
    check("dual_fwd1_hit", {63'd0, fwd1_hit}, {63'd0, exp_h});
    check("dual_fwd1_data", 64'(fwd1_data), exp_h ? 64'h22 : 64'd0);
    cyc();
    #1;
    check("dual_wd1", 64'(wd), 64'h22);
    cyc();
    cyc();

    // Fill to three entries, then reset mid-operation
    ra1 = 2; ra2 = 4;
    alu_valid = 1'b1; alu_addr = 2; alu_data = 32'hA1;
    mem_valid = 1'b1; mem_addr = 4; mem_data = 32'hB1;
    cyc();
    alu_data = 32'hA2; mem_data = 32'hB2;
    cyc();
    idle_inputs();
    #1;
    check("pre_rst_count", 64'(count), 64'd3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_we", {63'd0, we}, 64'd0);
    check("mid_rst_fwd1", {63'd0, fwd1_hit}, 64'd0);
    check("mid_rst_fwd2", {63'd0, fwd2_hit}, 64'd0);
    cyc();
    cyc();

    // Random traffic; producers hold their request until handshake
    n_enq = 0;
    alu_hs = 1'b0; mem_hs = 1'b0;
    for (int c = 0; c < 600 && n_enq < 300; c++) begin
      if (!alu_valid || alu_hs) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_addr  = AW'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!mem_valid || mem_hs) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_addr  = AW'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      ra1 = AW'($urandom_range(0, 7));
      ra2 = AW'($urandom_range(0, 7));
      cyc();
    end
    check("rand_enough_traffic", {63'd0, (n_enq >= 100)}, 64'd1);
    check("rand_count_bound", {63'd0, (max_cnt <= DEPTH)}, 64'd1);
    idle_inputs();
    for (int c = 0; c < DEPTH + 2; c++) cyc();
    check("drain_empty", 64'(count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
